// File: rtl/wb_register_file_pkg.sv
// Shared pipeline constants for the write-back / register-file slice.
package wb_register_file_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_register_file_if.sv
// MEM/WB write-back, ID read-port and issue/stall signals of the register file.
interface wb_register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] ReadDataDM;
  logic              MemToReg;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              issue_valid;
  logic              issue_load;
  logic [ADDR_W-1:0] issue_rd;
  logic              load_use_stall;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output ALUResult, ReadDataDM, MemToReg, RegWrite, WriteRegister,
    output rs_addr, rt_addr, issue_valid, issue_load, issue_rd,
    input  rs_data, rt_data, load_use_stall, wb_data
  );

  modport slave (
    input  ALUResult, ReadDataDM, MemToReg, RegWrite, WriteRegister,
    input  rs_addr, rt_addr, issue_valid, issue_load, issue_rd,
    output rs_data, rt_data, load_use_stall, wb_data
  );
endinterface

// File: rtl/wb_register_file_load_scoreboard.sv
// Per-register load-pending bits and the ID-stage load-use stall compare.
module load_scoreboard
  import wb_register_file_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_W,
  parameter int unsigned NUM_REGS  = NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_load,
  input  logic [ADDR_BITS-1:0] issue_rd,
  input  logic                 wb_we,
  input  logic [ADDR_BITS-1:0] wb_rd,
  input  logic [ADDR_BITS-1:0] rs_addr,
  input  logic [ADDR_BITS-1:0] rt_addr,
  output logic                 load_use_stall
);
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clear_mask;
  logic [NUM_REGS-1:0] pend_eff;

  always_comb begin
    clear_mask = '0;
    if (wb_we) clear_mask[wb_rd] = 1'b1;
    pend_eff = pending_q & ~clear_mask;
  end

  // Set is applied after clear so a newer load to the same register wins.
  always_comb begin
    pending_d = pending_q & ~clear_mask;
    if (issue_valid && issue_load && issue_rd != REG_ZERO[ADDR_BITS-1:0])
      pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    load_use_stall = (pend_eff[rs_addr] && rs_addr != REG_ZERO[ADDR_BITS-1:0]) ||
                     (pend_eff[rt_addr] && rt_addr != REG_ZERO[ADDR_BITS-1:0]);
  end
endmodule

// File: rtl/wb_register_file.sv
// WB data select, 32x32 architectural register file with write-first bypass,
// and the load-use scoreboard feeding the hazard logic.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int unsigned DATA_W = wb_register_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_register_file_pkg::ADDR_W,
  parameter int unsigned NREGS  = wb_register_file_pkg::NREGS
) (
  input logic               clk,
  input logic               rst,
  wb_register_file_if.slave rf
);
  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]            wb_data;
  logic                         wr_en;

  always_comb begin
    wb_data = rf.MemToReg ? rf.ReadDataDM : rf.ALUResult;
    wr_en   = rf.RegWrite && (rf.WriteRegister != REG_ZERO[ADDR_W-1:0]);
  end

  assign rf.wb_data = wb_data;

  // Register 0 is never written, so it reads zero without a special read case.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rf.WriteRegister] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  always_comb begin
    rf.rs_data = (wr_en && rf.WriteRegister == rf.rs_addr) ? wb_data : regs_q[rf.rs_addr];
    rf.rt_data = (wr_en && rf.WriteRegister == rf.rt_addr) ? wb_data : regs_q[rf.rt_addr];
  end

  load_scoreboard #(
    .ADDR_BITS (ADDR_W),
    .NUM_REGS  (NREGS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (rf.issue_valid),
    .issue_load     (rf.issue_load),
    .issue_rd       (rf.issue_rd),
    .wb_we          (rf.RegWrite),
    .wb_rd          (rf.WriteRegister),
    .rs_addr        (rf.rs_addr),
    .rt_addr        (rf.rt_addr),
    .load_use_stall (rf.load_use_stall)
  );
endmodule

// File: tb/tb_wb_register_file.sv
// Directed checks of write-back select, register file bypass and load-use stall.
module tb_wb_register_file;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;

  wb_register_file_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  wb_register_file #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.RegWrite    = 1'b0;
    rf.MemToReg    = 1'b0;
    rf.issue_valid = 1'b0;
    rf.issue_load  = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] val);
    rf.RegWrite      = 1'b1;
    rf.MemToReg      = 1'b0;
    rf.WriteRegister = rd;
    rf.ALUResult     = val;
    step();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rf.ALUResult = '0; rf.ReadDataDM = '0; rf.MemToReg = 1'b0; rf.RegWrite = 1'b0;
    rf.WriteRegister = '0; rf.rs_addr = '0; rf.rt_addr = '0;
    rf.issue_valid = 1'b0; rf.issue_load = 1'b0; rf.issue_rd = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Pre-write registers plus a pending load, then reset asynchronously
    wb_write(5'd1, 32'h1111_1111);
    wb_write(5'd31, 32'hAAAA_5555);
    rf.issue_valid = 1'b1; rf.issue_load = 1'b1; rf.issue_rd = 5'd6;
    step();
    idle();
    rf.rs_addr = 5'd1; rf.rt_addr = 5'd31;
    #1;
    check("prewrite_rs", rf.rs_data, 32'h1111_1111);
    check("prewrite_rt", rf.rt_data, 32'hAAAA_5555);
    rf.rs_addr = 5'd6;
    #1;
    check("prewrite_stall", {31'd0, rf.load_use_stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("reset_stall", {31'd0, rf.load_use_stall}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rf.rs_addr = 5'(i);
      rf.rt_addr = 5'(31 - i);
      #1;
      check("reset_rs", rf.rs_data, 32'd0);
      check("reset_rt", rf.rt_data, 32'd0);
    end
    step();
    rst = 1'b0;
    step();

    // Bypass then stored value, ALU path
    rf.RegWrite = 1'b1; rf.WriteRegister = 5'd5; rf.MemToReg = 1'b0;
    rf.ALUResult = 32'h0000_1234; rf.ReadDataDM = 32'h5555_0000; rf.rs_addr = 5'd5;
    #1;
    check("wb_alu", rf.wb_data, 32'h0000_1234);
    check("bypass_rs", rf.rs_data, 32'h0000_1234);
    step();
    idle();
    #1;
    check("reg5_rs", rf.rs_data, 32'h0000_1234);

    // Load path, bypass on rt
    rf.RegWrite = 1'b1; rf.MemToReg = 1'b1; rf.WriteRegister = 5'd9;
    rf.ReadDataDM = 32'hDEAD_BEEF; rf.ALUResult = 32'h0000_0001; rf.rt_addr = 5'd9;
    #1;
    check("wb_mem", rf.wb_data, 32'hDEAD_BEEF);
    check("bypass_rt", rf.rt_data, 32'hDEAD_BEEF);
    step();
    idle();
    #1;
    check("reg9_rt", rf.rt_data, 32'hDEAD_BEEF);

    // Both ports bypassing at once
    rf.RegWrite = 1'b1; rf.WriteRegister = 5'd12; rf.ALUResult = 32'h0BAD_F00D;
    rf.rs_addr = 5'd12; rf.rt_addr = 5'd12;
    #1;
    check("dual_bypass_rs", rf.rs_data, 32'h0BAD_F00D);
    check("dual_bypass_rt", rf.rt_data, 32'h0BAD_F00D);
    step();
    idle();

    // Writes to register 0 are discarded, including the bypass
    rf.RegWrite = 1'b1; rf.WriteRegister = 5'd0; rf.ALUResult = 32'hFFFF_FFFF;
    rf.rs_addr = 5'd0; rf.rt_addr = 5'd9;
    #1;
    check("wb_r0", rf.wb_data, 32'hFFFF_FFFF);
    check("r0_bypass", rf.rs_data, 32'd0);
    check("r0_other_port", rf.rt_data, 32'hDEAD_BEEF);
    step();
    idle();
    #1;
    check("r0_after", rf.rs_data, 32'd0);

    // Load to r0 never stalls
    rf.issue_valid = 1'b1; rf.issue_load = 1'b1; rf.issue_rd = 5'd0;
    step();
    idle();
    rf.rs_addr = 5'd0; rf.rt_addr = 5'd0;
    #1;
    check("r0_load_stall", {31'd0, rf.load_use_stall}, 32'd0);

    // Non-load issue sets nothing
    rf.issue_valid = 1'b1; rf.issue_load = 1'b0; rf.issue_rd = 5'd8;
    step();
    idle();
    rf.rs_addr = 5'd8;
    #1;
    check("nonload_stall", {31'd0, rf.load_use_stall}, 32'd0);

    // Load-use stall held until the WB write lands
    rf.issue_valid = 1'b1; rf.issue_load = 1'b1; rf.issue_rd = 5'd8;
    rf.rs_addr = 5'd2; rf.rt_addr = 5'd2;
    #1;
    check("issue_cycle_stall", {31'd0, rf.load_use_stall}, 32'd0);
    step();
    idle();
    rf.rs_addr = 5'd8;
    #1;
    check("load_use_rs", {31'd0, rf.load_use_stall}, 32'd1);
    step();
    rf.rs_addr = 5'd2; rf.rt_addr = 5'd8;
    #1;
    check("load_use_rt_hold", {31'd0, rf.load_use_stall}, 32'd1);
    step();
    rf.rs_addr = 5'd8; rf.rt_addr = 5'd0;
    rf.RegWrite = 1'b1; rf.MemToReg = 1'b1; rf.WriteRegister = 5'd8;
    rf.ReadDataDM = 32'hCAFE_F00D; rf.ALUResult = 32'h0000_0008;
    #1;
    check("release_stall", {31'd0, rf.load_use_stall}, 32'd0);
    check("release_data", rf.rs_data, 32'hCAFE_F00D);
    step();
    idle();
    #1;
    check("after_release_stall", {31'd0, rf.load_use_stall}, 32'd0);
    check("after_release_data", rf.rs_data, 32'hCAFE_F00D);

    // Set and clear on the same register: the newer load stays pending
    rf.issue_valid = 1'b1; rf.issue_load = 1'b1; rf.issue_rd = 5'd3;
    rf.RegWrite = 1'b1; rf.MemToReg = 1'b0; rf.WriteRegister = 5'd3; rf.ALUResult = 32'h0000_0033;
    rf.rs_addr = 5'd0; rf.rt_addr = 5'd0;
    step();
    idle();
    rf.rt_addr = 5'd3;
    #1;
    check("set_wins_stall", {31'd0, rf.load_use_stall}, 32'd1);
    check("set_wins_data", rf.rt_data, 32'h0000_0033);
    wb_write(5'd3, 32'h0000_0303);
    #1;
    check("set_wins_cleared", {31'd0, rf.load_use_stall}, 32'd0);

    // Pending load on r4 cleared by reset
    rf.issue_valid = 1'b1; rf.issue_load = 1'b1; rf.issue_rd = 5'd4;
    step();
    idle();
    rf.rs_addr = 5'd4; rf.rt_addr = 5'd9;
    #1;
    check("r4_pending", {31'd0, rf.load_use_stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("r4_reset_stall", {31'd0, rf.load_use_stall}, 32'd0);
    check("r4_reset_data", rf.rs_data, 32'd0);
    check("r9_reset_data", rf.rt_data, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("r4_after_reset_stall", {31'd0, rf.load_use_stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
